// File: rtl/axi_master_rw.sv
// AXI4 read/write master with independent read and write engines.
// Front-end request/stream ports are bridged onto the AXI4 AR/R and AW/W/B
// channels. Data paths are forwarded combinationally, with no buffering.
// Optional feature macro: AXI_MASTER_RESP_CHECK_EN. When defined, non-OKAY
// RRESP/BRESP set rd_err/wr_err. When undefined, response codes are ignored
// and wr_err is tied low.

module axi_master_rw #(
    parameter int                  DATA_WIDTH = 64,
    parameter int                  ADDR_WIDTH = 64,
    parameter int                  ID_WIDTH   = 4,
    parameter logic [ID_WIDTH-1:0] RD_ID      = '1,
    parameter logic [ID_WIDTH-1:0] WR_ID      = '1
) (
    input  logic                    clock,
    input  logic                    reset,

    // Read request and read data stream
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
    input  logic [7:0]              rd_req_len,
    input  logic [2:0]              rd_req_size,
    output logic                    rd_data_valid,
    input  logic                    rd_data_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_data_last,
    output logic                    rd_done,
    output logic                    rd_err,

    // Write request and write data stream
    input  logic                    wr_req_valid,
    output logic                    wr_req_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_req_addr,
    input  logic [7:0]              wr_req_len,
    input  logic [2:0]              wr_req_size,
    input  logic                    wr_data_valid,
    output logic                    wr_data_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_data_strb,
    output logic                    wr_done,
    output logic                    wr_err,

    // AXI4 write address channel
    output logic [ID_WIDTH-1:0]     axi_aw_id_o,
    output logic [ADDR_WIDTH-1:0]   axi_aw_addr_o,
    output logic [7:0]              axi_aw_len_o,
    output logic [2:0]              axi_aw_size_o,
    output logic [1:0]              axi_aw_burst_o,
    output logic                    axi_aw_lock_o,
    output logic [3:0]              axi_aw_cache_o,
    output logic [2:0]              axi_aw_prot_o,
    output logic [3:0]              axi_aw_qos_o,
    output logic [3:0]              axi_aw_region_o,
    output logic                    axi_aw_valid_o,
    input  logic                    axi_aw_ready_i,

    // AXI4 write data channel
    output logic [DATA_WIDTH-1:0]   axi_w_data_o,
    output logic [DATA_WIDTH/8-1:0] axi_w_strb_o,
    output logic                    axi_w_last_o,
    output logic                    axi_w_valid_o,
    input  logic                    axi_w_ready_i,

    // AXI4 write response channel
    input  logic [ID_WIDTH-1:0]     axi_b_id_i,
    input  logic [1:0]              axi_b_resp_i,
    input  logic                    axi_b_valid_i,
    output logic                    axi_b_ready_o,

    // AXI4 read address channel
    output logic [ID_WIDTH-1:0]     axi_ar_id_o,
    output logic [ADDR_WIDTH-1:0]   axi_ar_addr_o,
    output logic [7:0]              axi_ar_len_o,
    output logic [2:0]              axi_ar_size_o,
    output logic [1:0]              axi_ar_burst_o,
    output logic                    axi_ar_lock_o,
    output logic [3:0]              axi_ar_cache_o,
    output logic [2:0]              axi_ar_prot_o,
    output logic [3:0]              axi_ar_qos_o,
    output logic [3:0]              axi_ar_region_o,
    output logic                    axi_ar_valid_o,
    input  logic                    axi_ar_ready_i,

    // AXI4 read data channel
    input  logic [ID_WIDTH-1:0]     axi_r_id_i,
    input  logic [DATA_WIDTH-1:0]   axi_r_data_i,
    input  logic [1:0]              axi_r_resp_i,
    input  logic                    axi_r_last_i,
    input  logic                    axi_r_valid_i,
    output logic                    axi_r_ready_o
);

    localparam logic [2:0] MAX_SIZE   = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

    // Beats wider than the bus are not representable; clamp to full bus width.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > MAX_SIZE) ? MAX_SIZE : size;
    endfunction

    // ------------------------------------------------------------------
    // Request-ready enable: low in reset, high from the first clock after.
    // ------------------------------------------------------------------
    logic init_q, init_d;

    // Enable becomes 1 once any clock edge is seen out of reset.
    always_comb begin
        init_d = 1'b1;
    end

    // Enable register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            init_q <= 1'b0;
        end else begin
            // NOTE: state elements use non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            init_q <= init_d;
        end
    end

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    rd_state_e             rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q,  rd_addr_d;
    logic [7:0]            rd_len_q,   rd_len_d;
    logic [2:0]            rd_size_q,  rd_size_d;
    logic [8:0]            rd_beat_q,  rd_beat_d;   // beats received so far
    logic                  rd_err_q,   rd_err_d;
    logic                  rd_fire;

    assign rd_fire = (rd_state_q == R_DATA) && axi_r_valid_i && rd_data_ready;

    // Read next-state, request capture, beat checking and handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        rd_state_d    = rd_state_q;
        rd_addr_d     = rd_addr_q;
        rd_len_d      = rd_len_q;
        rd_size_d     = rd_size_q;
        rd_beat_d     = rd_beat_q;
        rd_err_d      = rd_err_q;
        rd_req_ready  = 1'b0;
        axi_ar_valid_o = 1'b0;
        axi_r_ready_o = 1'b0;
        rd_data_valid = 1'b0;
        rd_data_last  = 1'b0;
        rd_done       = 1'b0;

        case (rd_state_q)
            R_IDLE: begin
                rd_req_ready = init_q;
                if (rd_req_valid && init_q) begin
                    rd_addr_d  = rd_req_addr;
                    rd_len_d   = rd_req_len;
                    rd_size_d  = clamp_size(rd_req_size);
                    rd_beat_d  = 9'd0;
                    rd_err_d   = 1'b0;
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                axi_ar_valid_o = 1'b1;
                if (axi_ar_ready_i) begin
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                axi_r_ready_o = rd_data_ready;
                rd_data_valid = axi_r_valid_i;
                rd_data_last  = axi_r_last_i;
                if (rd_fire) begin
                    rd_beat_d = rd_beat_q + 9'd1;
                    // Early RLAST, or the expected final beat without RLAST.
                    if (axi_r_last_i && (rd_beat_q != {1'b0, rd_len_q})) begin
                        rd_err_d = 1'b1;
                    end
                    if (!axi_r_last_i && (rd_beat_q == {1'b0, rd_len_q})) begin
                        rd_err_d = 1'b1;
                    end
`ifdef AXI_MASTER_RESP_CHECK_EN
                    if (axi_r_resp_i != 2'b00) begin
                        rd_err_d = 1'b1;
                    end
`endif
                    // The burst always terminates on RLAST, even when malformed.
                    if (axi_r_last_i) begin
                        rd_state_d = R_RESP;
                    end
                end
            end
            R_RESP: begin
                rd_done    = 1'b1;
                rd_state_d = R_IDLE;
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase
    end

    // Read engine registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_size_q  <= '0;
            rd_beat_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
            rd_size_q  <= rd_size_d;
            rd_beat_q  <= rd_beat_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign rd_data = axi_r_data_i;
    assign rd_err  = rd_err_q;

    assign axi_ar_id_o     = RD_ID;
    assign axi_ar_addr_o   = rd_addr_q;
    assign axi_ar_len_o    = rd_len_q;
    assign axi_ar_size_o   = rd_size_q;
    assign axi_ar_burst_o  = BURST_INCR;
    assign axi_ar_lock_o   = 1'b0;
    assign axi_ar_cache_o  = 4'b0010;
    assign axi_ar_prot_o   = 3'b000;
    assign axi_ar_qos_o    = 4'b0000;
    assign axi_ar_region_o = 4'b0000;

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    wr_state_e             wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
    logic [7:0]            wr_len_q,   wr_len_d;
    logic [2:0]            wr_size_q,  wr_size_d;
    logic [7:0]            wr_cnt_q,   wr_cnt_d;    // beats remaining minus one
    logic                  wr_wdone_q, wr_wdone_d;  // final W beat accepted
    logic                  wr_w_open;
    logic                  wr_w_fire;
    logic                  wr_w_final;

    // W beats flow in both W_ADDR and W_DATA so AW and W may finish in any order.
    assign wr_w_open  = ((wr_state_q == W_ADDR) || (wr_state_q == W_DATA)) && !wr_wdone_q;
    assign wr_w_final = (wr_cnt_q == 8'd0);
    assign wr_w_fire  = wr_w_open && wr_data_valid && axi_w_ready_i;

    assign axi_w_valid_o = wr_w_open && wr_data_valid;
    assign wr_data_ready = wr_w_open && axi_w_ready_i;
    assign axi_w_last_o  = wr_w_open && wr_w_final;
    assign axi_w_data_o  = wr_data;
    assign axi_w_strb_o  = wr_data_strb;

`ifdef AXI_MASTER_RESP_CHECK_EN
    logic wr_err_q, wr_err_d;
`endif

    // Write next-state, beat down-counter and handshake outputs.
    always_comb begin
        wr_state_d     = wr_state_q;
        wr_addr_d      = wr_addr_q;
        wr_len_d       = wr_len_q;
        wr_size_d      = wr_size_q;
        wr_cnt_d       = wr_cnt_q;
        wr_wdone_d     = wr_wdone_q;
`ifdef AXI_MASTER_RESP_CHECK_EN
        wr_err_d       = wr_err_q;
`endif
        wr_req_ready   = 1'b0;
        axi_aw_valid_o = 1'b0;
        axi_b_ready_o  = 1'b0;
        wr_done        = 1'b0;

        if (wr_w_fire) begin
            if (wr_w_final) begin
                wr_wdone_d = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q - 8'd1;
            end
        end

        case (wr_state_q)
            W_IDLE: begin
                wr_req_ready = init_q;
                if (wr_req_valid && init_q) begin
                    wr_addr_d  = wr_req_addr;
                    wr_len_d   = wr_req_len;
                    wr_size_d  = clamp_size(wr_req_size);
                    wr_cnt_d   = wr_req_len;
                    wr_wdone_d = 1'b0;
`ifdef AXI_MASTER_RESP_CHECK_EN
                    wr_err_d   = 1'b0;
`endif
                    wr_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                axi_aw_valid_o = 1'b1;
                if (axi_aw_ready_i) begin
                    if (wr_wdone_q || (wr_w_fire && wr_w_final)) begin
                        wr_state_d = W_RESP;
                    end else begin
                        wr_state_d = W_DATA;
                    end
                end
            end
            W_DATA: begin
                if (wr_w_fire && wr_w_final) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                axi_b_ready_o = 1'b1;
                if (axi_b_valid_i) begin
                    wr_done = 1'b1;
`ifdef AXI_MASTER_RESP_CHECK_EN
                    if (axi_b_resp_i != 2'b00) begin
                        wr_err_d = 1'b1;
                    end
`endif
                    wr_state_d = W_IDLE;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
            end
        endcase
    end

    // Write engine registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_state_q <= W_IDLE;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_size_q  <= '0;
            wr_cnt_q   <= '0;
            wr_wdone_q <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            wr_size_q  <= wr_size_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_wdone_q <= wr_wdone_d;
        end
    end

`ifdef AXI_MASTER_RESP_CHECK_EN
    // Sticky write error flag, cleared by the next accepted write request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;
`else
    assign wr_err = 1'b0;
`endif

    assign axi_aw_id_o     = WR_ID;
    assign axi_aw_addr_o   = wr_addr_q;
    assign axi_aw_len_o    = wr_len_q;
    assign axi_aw_size_o   = wr_size_q;
    assign axi_aw_burst_o  = BURST_INCR;
    assign axi_aw_lock_o   = 1'b0;
    assign axi_aw_cache_o  = 4'b1111;
    assign axi_aw_prot_o   = 3'b000;
    assign axi_aw_qos_o    = 4'b0000;
    assign axi_aw_region_o = 4'b0000;

    // Response IDs are not used (single outstanding burst per direction);
    // response codes are only consumed when response checking is built in.
    logic unused_inputs;
    assign unused_inputs = ^{axi_b_id_i, axi_r_id_i, axi_r_resp_i, axi_b_resp_i};

endmodule

// File: doc/axi_master_rw.md
AXI_MASTER_RW -- requirements
Module: axi_master_rw

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: AXI and front-end data width; legal values are 32, 64 and 128.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64: address width.
REQ-003 SHALL have parameter ID_WIDTH, default 4: AXI ID width.
REQ-004 SHALL have parameter RD_ID, default all-ones: ARID value.
REQ-005 SHALL have parameter WR_ID, default all-ones: AWID value.
REQ-006 SHALL have port clock, in, 1: the single clock.
REQ-007 SHALL have port reset, in, 1: asynchronous, active-low reset.
REQ-008 SHALL have ports rd_req_valid/rd_req_ready, in/out, 1/1: read request handshake.
REQ-009 SHALL have ports rd_req_addr/rd_req_len/rd_req_size, in, ADDR_WIDTH/8/3: start address, beats-1, log2 bytes per beat.
REQ-010 SHALL have ports rd_data_valid/rd_data_ready/rd_data/rd_data_last, out/in/out/out, 1/1/DATA_WIDTH/1: read data stream.
REQ-011 SHALL have ports rd_done/rd_err, out, 1/1: single-cycle pulse at burst end, and error flag.
REQ-012 SHALL have ports wr_req_valid/wr_req_ready/wr_req_addr/wr_req_len/wr_req_size, same widths as the read request: write request.
REQ-013 SHALL have ports wr_data_valid/wr_data_ready/wr_data/wr_data_strb, in/out/in/in, 1/1/DATA_WIDTH/DATA_WIDTH/8: write data stream.
REQ-014 SHALL have ports wr_done/wr_err, out, 1/1: pulse on B handshake, and error flag.
REQ-015 SHALL have the AXI4 AW, W, B, AR and R channels with the standard signal set, named axi_<ch>_<sig>_o for outputs and axi_<ch>_<sig>_i for inputs.

Function
REQ-016 Read and write engines SHALL be independent and SHALL run concurrently.
REQ-017 Read FSM states SHALL be R_IDLE, R_ADDR, R_DATA and R_RESP; write FSM states SHALL be W_IDLE, W_ADDR, W_DATA and W_RESP.
REQ-018 rd_req_ready SHALL be 1 only in R_IDLE; on an accepted request the engine SHALL register addr, len and size and enter R_ADDR on the next cycle.
REQ-019 R_ADDR SHALL hold arvalid=1 with stable fields until arready, then enter R_DATA; arburst SHALL be INCR.
REQ-020 In R_DATA: rready = rd_data_ready; rd_data_valid = rvalid; rd_data = rdata; rd_data_last = rlast. The path SHALL be combinational, with zero latency and no buffering.
REQ-021 On the rvalid&&rready&&rlast beat the engine SHALL enter R_RESP and pulse rd_done for 1 cycle, then return to R_IDLE.
REQ-022 Beat counter: if rlast arrives before len+1 beats, or len+1 beats arrive without rlast, the engine SHALL set rd_err and still finish at rlast.
REQ-023 W_ADDR SHALL assert awvalid. W data SHALL be forwarded combinationally: wvalid = wr_data_valid; wr_data_ready = wready. W beats SHALL be accepted in W_ADDR and W_DATA, so AW and W may complete in either order.
REQ-024 wlast SHALL be 1 exactly on beat len+1, driven from an internal 8-bit down-counter. After the last W handshake and the AW handshake the engine SHALL enter W_RESP.
REQ-025 W_RESP SHALL drive bready=1. On bvalid it SHALL pulse wr_done for 1 cycle and return to W_IDLE. bready SHALL be 0 in every other state.
REQ-026 len=0 SHALL give a single-beat burst, with wlast asserted on the first beat.
REQ-027 len=255 SHALL give 256 beats; the counter SHALL NOT wrap early.
REQ-028 A request with size > log2(DATA_WIDTH/8) SHALL be clamped to log2(DATA_WIDTH/8).
REQ-029 axlock, axqos and axregion SHALL be 0. arcache SHALL be 4'b0010 and awcache 4'b1111. prot SHALL be 3'b000.
REQ-030 rd_err and wr_err SHALL be sticky until the next accepted request of the same direction.

Reset
REQ-031 Assertion of reset SHALL immediately force both FSMs to IDLE.
REQ-032 Under reset all valid, ready-to-AXI, done and err outputs SHALL be 0, and registered address, len and size SHALL be 0.
REQ-033 Reset mid-burst SHALL abandon the transaction. No pulse SHALL be generated after deassertion.
REQ-034 rd_req_ready and wr_req_ready SHALL go to 1 on the first clock after deassertion.

Configuration
REQ-035 With AXI_MASTER_RESP_CHECK_EN defined, rresp or bresp != 2'b00 on any beat or response SHALL set rd_err or wr_err respectively, in addition to REQ-022.
REQ-036 Without AXI_MASTER_RESP_CHECK_EN, resp SHALL be ignored, and only REQ-022 SHALL set rd_err; wr_err SHALL be tied to 0.

Verification
REQ-037 Read, addr 0x8000_0000, len=3, size=3, arready delayed 2 cycles -> arvalid held 3 cycles, 4 beats with rlast on the 4th, rd_done pulses once, rd_err=0.
REQ-038 Write, len=0, strb 0x0F, wready=1, W before AW, bvalid 1 cycle later -> single beat with wlast=1, wr_done pulses once, wr_err=0.
REQ-039 Concurrent read len=7 and write len=7 with random ready/valid gaps -> both complete independently with 8 beats each and no beat lost or duplicated.
REQ-040 Write len=255 -> exactly 256 W beats, wlast only on beat 256.
REQ-041 Read with bresp/rresp=2'b10 on beat 2 -> rd_err=1 when the macro is defined, rd_err=0 when it is not. Read with rlast on beat 3 of len=3 -> rd_err=1.
REQ-042 Reset asserted during W_DATA of a len=7 write -> awvalid, wvalid and bready drop asynchronously, wr_done is never pulsed, and wr_req_ready=1 one cycle after release.
